// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph patterns for hex digits 0-F,
// the all-off pattern and the glyph type used by the scan decoder.
package seg7_pkg;

    typedef logic [6:0] seg7_glyph_t;

    localparam seg7_glyph_t GLYPH_0 = 7'h40;
    localparam seg7_glyph_t GLYPH_1 = 7'h79;
    localparam seg7_glyph_t GLYPH_2 = 7'h24;
    localparam seg7_glyph_t GLYPH_3 = 7'h30;
    localparam seg7_glyph_t GLYPH_4 = 7'h19;
    localparam seg7_glyph_t GLYPH_5 = 7'h12;
    localparam seg7_glyph_t GLYPH_6 = 7'h02;
    localparam seg7_glyph_t GLYPH_7 = 7'h78;
    localparam seg7_glyph_t GLYPH_8 = 7'h00;
    localparam seg7_glyph_t GLYPH_9 = 7'h18;
    localparam seg7_glyph_t GLYPH_A = 7'h08;
    localparam seg7_glyph_t GLYPH_B = 7'h03;
    localparam seg7_glyph_t GLYPH_C = 7'h46;
    localparam seg7_glyph_t GLYPH_D = 7'h21;
    localparam seg7_glyph_t GLYPH_E = 7'h06;
    localparam seg7_glyph_t GLYPH_F = 7'h0E;

    localparam seg7_glyph_t SEG_BLANK = 7'h7F;

    // Entry n holds the glyph for nibble n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup: active-low segment pattern to hex nibble, with a flag
// saying whether the pattern is one of the sixteen legal glyphs.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  seg7_glyph_t i_seg,
    output logic        o_ok,
    output logic [3:0]  o_nibble
);

    always_comb begin
        o_ok     = 1'b0;
        o_nibble = 4'h0;
        for (int n = 0; n < 16; n++) begin
            if (i_seg == GLYPH_TABLE[n]) begin
                o_ok     = 1'b1;
                o_nibble = 4'(n);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed active-low seven-segment bus, debounces each (anode, segment)
// pattern and rebuilds the hex digit shown at every position, with freshness timeout.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65536
)
(
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [NDIG-1:0]                       i_an,
    input  logic [6:0]                            i_seg,
    output logic [4*NDIG-1:0]                     o_digits,
    output logic [NDIG-1:0]                       o_dig_valid,
    output logic [NDIG-1:0]                       o_dig_blank,
    output logic [NDIG-1:0]                       o_dig_err,
    output logic                                  o_upd,
    output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] o_upd_idx
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [NDIG-1:0]   r_last_an;
    seg7_glyph_t       r_last_seg;
    logic [CW-1:0]     r_cnt;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_valid;
    logic [NDIG-1:0]   r_blank;
    logic [NDIG-1:0]   r_err;
    logic              r_upd;
    logic [IW-1:0]     r_upd_idx;
    logic [TW-1:0]     r_to [NDIG];

    logic              w_onehot;
    logic              w_match;
    logic              w_commit;
    logic              w_blank;
    logic              w_ok;
    logic [3:0]        w_nib;
    logic [IW-1:0]     w_pos;
    logic [NDIG-1:0]   w_to_hit;

    seg7_to_hex u_decode (
        .i_seg    (r_last_seg),
        .o_ok     (w_ok),
        .o_nibble (w_nib)
    );

    assign w_onehot = $onehot(~i_an);
    assign w_match  = w_onehot && (i_an == r_last_an) && (i_seg == r_last_seg);
    // Commit fires only on the step into saturation, so a held pattern commits once.
    assign w_commit = w_match && (r_cnt == CW'(STABLE_CYCLES - 1));
    assign w_blank  = (r_last_seg == SEG_BLANK);

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!r_last_an[i]) w_pos = IW'(i);
        end
    end

    always_comb begin
        w_to_hit = '0;
        for (int i = 0; i < NDIG; i++) begin
            w_to_hit[i] = (r_to[i] == TW'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_an  <= '1;
            r_last_seg <= SEG_BLANK;
            r_cnt      <= '0;
        end else begin
            r_last_an  <= i_an;
            r_last_seg <= i_seg;
            if (w_match) begin
                if (r_cnt != CW'(STABLE_CYCLES)) r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= w_onehot ? CW'(1) : '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digits  <= '0;
            r_valid   <= '0;
            r_blank   <= '0;
            r_err     <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= '0;
        end else begin
            r_upd <= w_commit;
            if (w_commit) r_upd_idx <= w_pos;
            for (int i = 0; i < NDIG; i++) begin
                if (w_commit && (w_pos == IW'(i))) begin
                    if (w_blank) begin
                        r_digits[4*i +: 4] <= 4'h0;
                        r_valid[i]         <= 1'b1;
                        r_blank[i]         <= 1'b1;
                        r_err[i]           <= 1'b0;
                    end else if (w_ok) begin
                        r_digits[4*i +: 4] <= w_nib;
                        r_valid[i]         <= 1'b1;
                        r_blank[i]         <= 1'b0;
                        r_err[i]           <= 1'b0;
                    end else begin
                        r_valid[i]         <= 1'b0;
                        r_blank[i]         <= 1'b0;
                        r_err[i]           <= 1'b1;
                    end
                end else if (w_to_hit[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // A commit to a position takes priority over its timeout on the same edge.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NDIG; i++) begin
            if (i_rst) begin
                r_to[i] <= '0;
            end else if (w_commit && (w_pos == IW'(i))) begin
                r_to[i] <= '0;
            end else if (r_to[i] != TW'(TIMEOUT)) begin
                r_to[i] <= r_to[i] + 1'b1;
            end
        end
    end

    assign o_digits    = r_digits;
    assign o_dig_valid = r_valid;
    assign o_dig_blank = r_blank;
    assign o_dig_err   = r_err;
    assign o_upd       = r_upd;
    assign o_upd_idx   = r_upd_idx;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder: stimulus pushes the expected commit,
// a negedge monitor pops and compares on every update pulse.
module tb_seg_scan_decoder;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] nib;
        logic       valid;
        logic       blank;
        logic       err;
    } scoreEntry_t;

    logic        clk;
    logic        rst;
    logic [3:0]  anSel;
    logic [6:0]  segIn;

    logic [15:0] digits;
    logic [3:0]  digValid;
    logic [3:0]  digBlank;
    logic [3:0]  digErr;
    logic        upd;
    logic [1:0]  updIdx;

    logic [15:0] toDigits;
    logic [3:0]  toValid;
    logic [3:0]  toBlank;
    logic [3:0]  toErr;
    logic        toUpd;
    logic [1:0]  toUpdIdx;

    scoreEntry_t sbQ[$];
    scoreEntry_t monEntry;
    logic [6:0]  glyphs [16];
    logic        prevUpd;
    int          checks;
    int          errors;
    int          updCount;
    int          pushCount;

    seg_scan_decoder #(.NDIG(4), .STABLE_CYCLES(4), .TIMEOUT(65536)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_an        (anSel),
        .i_seg       (segIn),
        .o_digits    (digits),
        .o_dig_valid (digValid),
        .o_dig_blank (digBlank),
        .o_dig_err   (digErr),
        .o_upd       (upd),
        .o_upd_idx   (updIdx)
    );

    seg_scan_decoder #(.NDIG(4), .STABLE_CYCLES(4), .TIMEOUT(16)) dutTo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_an        (anSel),
        .i_seg       (segIn),
        .o_digits    (toDigits),
        .o_dig_valid (toValid),
        .o_dig_blank (toBlank),
        .o_dig_err   (toErr),
        .o_upd       (toUpd),
        .o_upd_idx   (toUpdIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic expectCommit(input logic [1:0] idx, input logic [3:0] nib,
                                input logic valid, input logic blank, input logic err);
        scoreEntry_t e;
        e.idx   = idx;
        e.nib   = nib;
        e.valid = valid;
        e.blank = blank;
        e.err   = err;
        sbQ.push_back(e);
        pushCount++;
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int n);
        anSel = an;
        segIn = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every update pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (upd) begin
                updCount++;
                checkOutput("updGap", {31'b0, prevUpd}, 32'd0);
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedUpd actual idx=%0d required no update", updIdx);
                end else begin
                    monEntry = sbQ.pop_front();
                    checkOutput("updIdx",  {30'b0, updIdx}, {30'b0, monEntry.idx});
                    checkOutput("digit",   {28'b0, digits[4*monEntry.idx +: 4]}, {28'b0, monEntry.nib});
                    checkOutput("valid",   {31'b0, digValid[monEntry.idx]}, {31'b0, monEntry.valid});
                    checkOutput("blank",   {31'b0, digBlank[monEntry.idx]}, {31'b0, monEntry.blank});
                    checkOutput("err",     {31'b0, digErr[monEntry.idx]},   {31'b0, monEntry.err});
                end
            end
            prevUpd = upd;
        end else begin
            prevUpd = 1'b0;
        end
    end

    initial begin
        glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        checks    = 0;
        errors    = 0;
        updCount  = 0;
        pushCount = 0;
        prevUpd   = 1'b0;
        rst   = 1'b1;
        anSel = 4'b1111;
        segIn = 7'h7F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstDigits", {16'b0, digits}, 32'h0);
        checkOutput("rstValid",  {28'b0, digValid}, 32'h0);
        checkOutput("rstBlank",  {28'b0, digBlank}, 32'h0);
        checkOutput("rstErr",    {28'b0, digErr}, 32'h0);
        checkOutput("rstUpd",    {31'b0, upd}, 32'h0);
        checkOutput("rstUpdIdx", {30'b0, updIdx}, 32'h0);
        rst = 1'b0;

        // Basic commit of a 5 on position 0.
        expectCommit(2'd0, 4'h5, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1110, 7'h12, 6);
        @(negedge clk);
        checkOutput("firstDigit", {28'b0, digits[3:0]}, 32'h5);
        checkOutput("firstValid", {28'b0, digValid}, 32'h1);

        // All sixteen glyphs on position 2.
        for (int k = 0; k < 16; k++) begin
            expectCommit(2'd2, 4'(k), 1'b1, 1'b0, 1'b0);
            applyStimulus(4'b1011, glyphs[k], 5);
        end
        @(negedge clk);
        checkOutput("sweepDigit", {28'b0, digits[11:8]}, 32'hF);
        checkOutput("sweepErr",   {28'b0, digErr}, 32'h0);

        // Short glitch of a 3 must never commit; the following 2 does.
        applyStimulus(4'b1101, 7'h30, 3);
        expectCommit(2'd1, 4'h2, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1101, 7'h24, 4);
        @(negedge clk);
        checkOutput("glitchDigit", {28'b0, digits[7:4]}, 32'h2);

        // Illegal pattern holds the digit, then blank.
        expectCommit(2'd3, 4'hF, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0111, 7'h0E, 4);
        expectCommit(2'd3, 4'hF, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0111, 7'h7E, 4);
        @(negedge clk);
        checkOutput("illegalErr",   {31'b0, digErr[3]}, 32'h1);
        checkOutput("illegalValid", {31'b0, digValid[3]}, 32'h0);
        checkOutput("illegalDigit", {28'b0, digits[15:12]}, 32'hF);
        expectCommit(2'd3, 4'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b0111, 7'h7F, 4);
        @(negedge clk);
        checkOutput("blankFlag",  {31'b0, digBlank[3]}, 32'h1);
        checkOutput("blankValid", {31'b0, digValid[3]}, 32'h1);

        // Anode change with identical segments restarts the run.
        applyStimulus(4'b1110, 7'h79, 3);
        expectCommit(2'd1, 4'h1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1101, 7'h79, 4);
        @(negedge clk);
        checkOutput("anChgPos0", {28'b0, digits[3:0]}, 32'h5);
        checkOutput("anChgPos1", {28'b0, digits[7:4]}, 32'h1);

        // Multi-low and all-high anodes: nothing commits, nothing changes.
        checkOutput("preIdleDigits", {16'b0, digits}, 32'h0F15);
        applyStimulus(4'b1100, 7'h12, 10);
        applyStimulus(4'b1111, 7'h12, 10);
        @(negedge clk);
        checkOutput("idleDigits", {16'b0, digits}, 32'h0F15);
        checkOutput("idleValid",  {28'b0, digValid}, 32'hF);
        checkOutput("idleBlank",  {28'b0, digBlank}, 32'h8);
        checkOutput("idleErr",    {28'b0, digErr}, 32'h0);

        // Timeout on the short-timeout instance: valid falls 16 cycles after the commit.
        expectCommit(2'd0, 4'h3, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1110, 7'h30, 4);
        expectCommit(2'd1, 4'h3, 1'b1, 1'b0, 1'b0);
        anSel = 4'b1101;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput($sformatf("toValid%0d", k), {31'b0, toValid[0]}, (k < 16) ? 32'h1 : 32'h0);
        end
        checkOutput("toDigitHeld", {28'b0, toDigits[3:0]}, 32'h3);
        checkOutput("longValid",   {31'b0, digValid[0]}, 32'h1);

        // Reset mid-run discards the partial debounce.
        anSel = 4'b0111;
        segIn = 7'h19;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstDigits",  {16'b0, digits}, 32'h0);
        checkOutput("midRstValid",   {28'b0, digValid}, 32'h0);
        checkOutput("midRstUpd",     {31'b0, upd}, 32'h0);
        checkOutput("midRstToDig",   {16'b0, toDigits}, 32'h0);
        checkOutput("midRstToFlags", {16'b0, toValid, toBlank, toErr, 4'b0}, 32'h0);
        checkOutput("midRstToUpd",   {29'b0, toUpd, toUpdIdx}, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("postRstNoUpd", {31'b0, upd}, 32'h0);
        expectCommit(2'd3, 4'h4, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("postRstUpd", {31'b0, upd}, 32'h1);

        repeat (3) @(negedge clk);
        checkOutput("sbEmpty",  sbQ.size(), 32'd0);
        checkOutput("updTotal", updCount, pushCount);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. It watches a time-multiplexed, active-low display bus (anode selects plus segment lines) and rebuilds the hex digit currently shown in each position. Each captured pattern is debounced, decoded back to a nibble and checked against the valid glyph set. It sits on the test and loopback side of the game board, so the scoreboard/checker can read the displayed digits as numbers.

## Interface
- `NDIG`, default 4: number of multiplexed digit positions.
- `STABLE_CYCLES`, default 4 (≥2): consecutive identical samples required before a digit is committed.
- `TIMEOUT`, default 65536: cycles without a commit before a digit's valid bit clears.
- `clk`  in  1: sole clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `an`  in  NDIG: anode selects, active-low; exactly one low selects digit i. Synchronous to `clk`.
- `seg`  in  7: segments, active-low, bit 0 = a … bit 6 = g.
- `digits`  out  4*NDIG: decoded nibble per position; digit i occupies `[4i+3:4i]`.
- `dig_valid`  out  NDIG: position holds a fresh, legal glyph.
- `dig_blank`  out  NDIG: last committed pattern was all-off (7'h7F).
- `dig_err`  out  NDIG: last committed pattern was not a legal glyph.
- `upd`  out  1: one-cycle pulse on every commit.
- `upd_idx`  out  $clog2(NDIG): position committed, valid while `upd` is high.

## Operation
- Glyph table (seg[6:0], active-low), nibbles 0–F in order: 40, 79, 24, 30, 19, 12, 02, 78, 00, 18, 08, 03, 46, 21, 06, 0E (hex). 9 has no d segment, so 9 is 0x18.
- Tracker registers: `last_an`, `last_seg`, `cnt` (saturating at STABLE_CYCLES).
- On each edge:
  - If `an` is one-hot-low and equals `last_an`, and `seg` equals `last_seg`: `cnt` ← min(`cnt`+1, STABLE_CYCLES).
  - Otherwise: `cnt` ← 1 (or 0 if `an` is not one-hot-low). `last_an`/`last_seg` are always loaded from the inputs.
- Commit happens on the edge where `cnt` goes from STABLE_CYCLES−1 to STABLE_CYCLES. A held pattern commits exactly once; the next commit needs a change in `an` or `seg`.
- Commit to position i:
  - Legal glyph: `digits[i]` ← nibble; `dig_valid[i]`=1, `dig_blank[i]`=0, `dig_err[i]`=0.
  - 7'h7F: `digits[i]` ← 0; `dig_valid[i]`=1, `dig_blank[i]`=1, `dig_err[i]`=0.
  - Any other pattern: `digits[i]` held; `dig_valid[i]`=0, `dig_err[i]`=1, `dig_blank[i]`=0.
  - In every case `upd`=1 and `upd_idx`=i on the following cycle.
- `an` all-high (blanking interval) or more than one low: no commit, `cnt`=0. This is not an error.
- Timeout: each position has a counter that clears on commit to that position and saturates at TIMEOUT. On reaching TIMEOUT, `dig_valid[i]` ← 0; `digits`, `dig_blank` and `dig_err` are held.

## Timing
- Reset values:
  - `digits`=0, `dig_valid`=0, `dig_blank`=0, `dig_err`=0, `upd`=0, `upd_idx`=0.
  - `cnt`=0, `last_an`=all-ones, `last_seg`=7'h7F, timeout counters=0.
- Reset asserted mid-run discards any partial debounce. The first commit after reset needs a full STABLE_CYCLES run.
- Latency: with inputs stable before edge 1, the commit occurs at edge STABLE_CYCLES. `digits`, flags and `upd` are visible in the cycle after that edge (registered outputs).
- An input change at the edge STABLE_CYCLES−1 restarts the run and produces no commit.
- An anode change with identical `seg` counts as a change: `cnt` restarts and the new position needs its own full run.
- `upd` is never high on two consecutive cycles when STABLE_CYCLES ≥ 2.
- Timeout and commit to the same position on the same edge: the commit wins and the counter clears.

## Structure
- Package `seg7_pkg`: the 16 glyph constants, `SEG_BLANK`=7'h7F, and `seg7_glyph_t` (7-bit type).
- Sub-module `seg7_to_hex`: combinational decode, seg[6:0] → {ok, nibble[3:0]}, built on the package table. Instantiated once, on `last_seg`.
- Top level holds the tracker, the commit/flag registers and the NDIG timeout counters.

## Test plan
- Reset, then `an`=4'b1110, `seg`=7'h12 held 6 cycles -> one `upd` pulse after edge 4, `upd_idx`=0, `digits[3:0]`=5, `dig_valid`=4'b0001.
- Sweep all 16 glyphs on position 2, each held 5 cycles -> `digits[11:8]` reads 0…F in order, 16 `upd` pulses, `dig_err`=0 throughout.
- Glitch: position 1 shows 7'h30 for 3 cycles, then 7'h24 for 4 -> single commit, `digits[7:4]`=2, never 3.
- `seg`=7'h7E held 4 cycles on position 3 -> `dig_err[3]`=1, `dig_valid[3]`=0, `digits[15:12]` unchanged. Then 7'h7F -> `dig_blank[3]`=1, `dig_valid[3]`=1.
- `an`=4'b1100 or 4'b1111 for 20 cycles -> no `upd`, all outputs unchanged.
- TIMEOUT=16: commit position 0, then drive `an`=4'b1101 → `dig_valid[0]` falls exactly 16 cycles after the commit. Asserting `rst` mid-run clears all outputs next cycle.
